// File: rtl/btb_update_pkg.sv
// Shared types and constants for the 2-way, 8-set BTB: predictor state codes,
// the 2-bit training function and the 64-bit entry field offsets.
package btb_update_pkg;

    typedef enum logic [1:0] {
        StStrongNt = 2'b00,
        StWeakNt   = 2'b01,
        StStrongT  = 2'b10,
        StWeakT    = 2'b11
    } pred_state_e;

    localparam int unsigned NumSets = 8;
    localparam int unsigned IndexW  = 3;
    localparam int unsigned TagW    = 27;
    localparam int unsigned EntryW  = 64;

    localparam int unsigned EntryValid = 63;
    localparam int unsigned EntryTagHi = 62;
    localparam int unsigned EntryTagLo = 36;
    localparam int unsigned EntryTgtHi = 35;
    localparam int unsigned EntryTgtLo = 4;
    localparam int unsigned EntryStHi  = 3;
    localparam int unsigned EntryStLo  = 2;

    localparam logic [31:0] ZERO_32BIT = 32'h0000_0000;

    // Weak states sit between the strong ones, so a single misprediction from a
    // strong state only weakens it.
    function automatic pred_state_e pred_next_state(input pred_state_e cur, input logic taken);
        pred_state_e nxt;
        unique case (cur)
            StStrongNt: nxt = taken ? StWeakNt  : StStrongNt;
            StWeakNt:   nxt = taken ? StWeakT   : StStrongNt;
            StWeakT:    nxt = taken ? StStrongT : StWeakNt;
            StStrongT:  nxt = taken ? StStrongT : StWeakT;
            default:    nxt = StStrongNt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Tag compare and allocation victim choice for one BTB set.
// Way index encoding: 0 = way1 (upper half of the set), 1 = way2.
module btb_victim_sel
    import btb_update_pkg::*;
(
    input  logic [2*EntryW-1:0] set_data,
    input  logic                lru_bit,
    input  logic [TagW-1:0]     tag,
    output logic                hit,
    output logic                hit_way,
    output logic                alloc_way
);

    logic [EntryW-1:0] way1;
    logic [EntryW-1:0] way2;
    logic              hit1;
    logic              hit2;
    logic              unused_fields;

    assign way1 = set_data[2*EntryW-1:EntryW];
    assign way2 = set_data[EntryW-1:0];

    assign hit1 = way1[EntryValid] && (way1[EntryTagHi:EntryTagLo] == tag);
    assign hit2 = way2[EntryValid] && (way2[EntryTagHi:EntryTagLo] == tag);

    assign hit     = hit1 || hit2;
    assign hit_way = !hit1;

    // LRU bit names the most recent way, so the victim is its complement.
    always_comb begin
        if (!way1[EntryValid]) begin
            alloc_way = 1'b0;
        end else if (!way2[EntryValid]) begin
            alloc_way = 1'b1;
        end else begin
            alloc_way = !lru_bit;
        end
    end

    assign unused_fields = ^{way1[EntryTgtHi:0], way2[EntryTgtHi:0]};

endmodule

// File: rtl/btb_update.sv
// BTB storage, update read-modify-write and flush sweep.
// Optional BTB_STATS_EN adds saturating allocation / eviction counters.
module btb_update
    import btb_update_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [IndexW-1:0]   read_index,
    input  logic                read_en,
    input  logic                next_LRU_read,
    output logic [2*EntryW-1:0] read_set,
    output logic [NumSets-1:0]  LRU,
    input  logic                update_en,
    input  logic [31:0]         update_pc,
    input  logic                update_taken,
    input  logic [31:0]         update_target,
    input  logic                flush_req,
    output logic                flush_busy
`ifdef BTB_STATS_EN
    ,
    output logic [15:0]         alloc_count,
    output logic [15:0]         evict_count
`endif
);

    typedef enum logic [0:0] {StIdle, StFlush} flush_state_e;

    logic [2*EntryW-1:0] sets_q [NumSets];
    logic [NumSets-1:0]  lru_q;
    flush_state_e        state_q, state_d;
    logic [IndexW-1:0]   cnt_q, cnt_d;
    logic                flushing;

    logic [IndexW-1:0]   upd_index;
    logic [TagW-1:0]     upd_tag;
    logic [2*EntryW-1:0] cur_set;
    logic [2*EntryW-1:0] new_set;
    logic [EntryW-1:0]   hit_entry;
    logic [EntryW-1:0]   new_entry;
    logic                hit, hit_way, alloc_way;
    logic                wr_way;
    logic                upd_write;
    logic                alloc;
    logic                evict;
    logic                unused_pc;

    assign upd_index = update_pc[4:2];
    assign upd_tag   = update_pc[31:5];
    assign cur_set   = sets_q[upd_index];
    assign unused_pc = ^update_pc[1:0];

    btb_victim_sel u_victim_sel (
        .set_data  (cur_set),
        .lru_bit   (lru_q[upd_index]),
        .tag       (upd_tag),
        .hit       (hit),
        .hit_way   (hit_way),
        .alloc_way (alloc_way)
    );

    assign upd_write = update_en && !flushing && (hit || update_taken);
    assign alloc     = upd_write && !hit;
    assign evict     = alloc && cur_set[EntryW + EntryValid] && cur_set[EntryValid];
    assign wr_way    = hit ? hit_way : alloc_way;

    always_comb begin
        hit_entry = hit_way ? cur_set[EntryW-1:0] : cur_set[2*EntryW-1:EntryW];
        if (hit) begin
            new_entry = hit_entry;
            new_entry[EntryStHi:EntryStLo] =
                pred_next_state(pred_state_e'(hit_entry[EntryStHi:EntryStLo]), update_taken);
            if (update_taken) begin
                new_entry[EntryTgtHi:EntryTgtLo] = update_target;
            end
        end else begin
            new_entry = {1'b1, upd_tag, update_target, StWeakT, 2'b00};
        end
        new_set = cur_set;
        if (wr_way) begin
            new_set[EntryW-1:0] = new_entry;
        end else begin
            new_set[2*EntryW-1:EntryW] = new_entry;
        end
    end

    // Flush FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flush FSM: next state. A new request restarts the sweep from set 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (flush_req) begin
                    state_d = StFlush;
                    cnt_d   = '0;
                end
            end
            StFlush: begin
                if (flush_req) begin
                    cnt_d = '0;
                end else if (cnt_q == IndexW'(NumSets - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Flush FSM: outputs.
    always_comb begin
        flushing   = (state_q == StFlush);
        flush_busy = flushing;
    end

    // Update LRU write is issued after the read-side commit so it wins on a shared index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumSets; i++) begin
                sets_q[i] <= '0;
            end
            lru_q <= '0;
        end else if (flushing) begin
            sets_q[cnt_q][EntryW + EntryValid] <= 1'b0;
            sets_q[cnt_q][EntryValid]          <= 1'b0;
            lru_q[cnt_q]                       <= 1'b0;
        end else begin
            if (read_en) begin
                lru_q[read_index] <= next_LRU_read;
            end
            if (upd_write) begin
                sets_q[upd_index] <= new_set;
                lru_q[upd_index]  <= wr_way;
            end
        end
    end

    assign read_set = flushing ? {4{ZERO_32BIT}} : sets_q[read_index];
    assign LRU      = lru_q;

`ifdef BTB_STATS_EN
    logic [15:0] alloc_cnt_q;
    logic [15:0] evict_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_cnt_q <= '0;
            evict_cnt_q <= '0;
        end else begin
            if (alloc && (alloc_cnt_q != 16'hFFFF)) begin
                alloc_cnt_q <= alloc_cnt_q + 16'd1;
            end
            if (evict && (evict_cnt_q != 16'hFFFF)) begin
                evict_cnt_q <= evict_cnt_q + 16'd1;
            end
        end
    end

    assign alloc_count = alloc_cnt_q;
    assign evict_count = evict_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = ^{alloc, evict};
`endif

endmodule
